// File: rtl/gba_direct_sound_bank.sv
// gba_direct_sound_bank: per-channel 32-bit sample FIFOs, byte sequencers and a saturating stereo mixer
module gba_direct_sound_bank #(
  parameter int NUM_CH = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int OUT_W = 16,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     gba_clk,
  input  logic                     reset,
  input  logic [1:0]               timer_ovf,
  input  logic [NUM_CH-1:0]        fifo_we,
  input  logic [31:0]              fifo_wdata,
  input  logic [NUM_CH-1:0]        fifo_clr,
  input  logic [NUM_CH-1:0]        ch_timer_sel,
  input  logic [NUM_CH-1:0]        ch_full_vol,
  input  logic [NUM_CH-1:0]        ch_en_l,
  input  logic [NUM_CH-1:0]        ch_en_r,
  input  logic                     master_en,
  output logic [NUM_CH-1:0]        sound_req,
  output logic [NUM_CH*LW-1:0]     fifo_level,
  output logic signed [OUT_W-1:0]  out_l,
  output logic signed [OUT_W-1:0]  out_r,
  output logic                     out_valid
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = OUT_W + $clog2(NUM_CH) + 1;
  localparam logic signed [SW-1:0] MAXV = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = ~MAXV;
  typedef enum logic {EMPTY, LOADED} state_t;
  logic [NUM_CH*8-1:0] samples;
  logic [NUM_CH-1:0] upd;
  genvar n;
  for (n = 0; n < NUM_CH; n++) begin : g_ch
    logic [31:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [LW-1:0] level, nlevel;
    logic [31:0] word;
    logic [1:0] idx;
    logic signed [7:0] smp;
    logic req, chg, clr, tick, pop, wr;
    state_t st;
    always_comb begin
      clr = fifo_clr[n] | ~master_en;
      tick = timer_ovf[ch_timer_sel[n]];
      pop = st == EMPTY && level != '0;
      wr = fifo_we[n] && (level < LW'(FIFO_DEPTH) || pop);
      nlevel = level + LW'(wr) - LW'(pop);
    end
    // storage is never reset; the pointers alone define its contents
    always_ff @(posedge gba_clk)
      if (wr) mem[wp] <= fifo_wdata;
    always_ff @(posedge gba_clk or posedge reset)
      if (reset) begin
        wp <= '0;
        rp <= '0;
        level <= '0;
        word <= '0;
        idx <= '0;
        smp <= '0;
        req <= 1'b0;
        chg <= 1'b0;
        st <= EMPTY;
      end else if (clr) begin
        wp <= '0;
        rp <= '0;
        level <= '0;
        idx <= '0;
        smp <= '0;
        req <= 1'b0;
        chg <= master_en;
        st <= EMPTY;
      end else begin
        wp <= wp + AW'(wr);
        rp <= rp + AW'(pop);
        level <= nlevel;
        req <= pop && nlevel <= LW'(FIFO_DEPTH / 2);
        chg <= st == LOADED && tick;
        if (pop) begin
          word <= mem[rp];
          idx <= '0;
          st <= LOADED;
        end else if (st == LOADED && tick) begin
          smp <= word[8*idx +: 8];
          idx <= idx + 2'd1;
          if (idx == 2'd3) st <= EMPTY;
        end
      end
    assign samples[8*n +: 8] = smp;
    assign upd[n] = chg;
    assign sound_req[n] = req;
    assign fifo_level[LW*n +: LW] = level;
  end
  logic signed [SW-1:0] sum_l, sum_r, c;
  always_comb begin
    sum_l = '0;
    sum_r = '0;
    c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = SW'(signed'(samples[8*i +: 8])) <<< (ch_full_vol[i] ? OUT_W - 9 : OUT_W - 10);
      sum_l = sum_l + (ch_en_l[i] ? c : '0);
      sum_r = sum_r + (ch_en_r[i] ? c : '0);
    end
  end
  function automatic logic signed [OUT_W-1:0] sat(input logic signed [SW-1:0] v);
    return v > MAXV ? OUT_W'(MAXV) : v < MINV ? OUT_W'(MINV) : OUT_W'(v);
  endfunction
  always_ff @(posedge gba_clk or posedge reset)
    if (reset) begin
      out_l <= '0;
      out_r <= '0;
      out_valid <= 1'b0;
    end else if (!master_en) begin
      out_l <= '0;
      out_r <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= |upd;
      if (|upd) begin
        out_l <= sat(sum_l);
        out_r <= sat(sum_r);
      end
    end
endmodule
